// File: rtl/led_display_bcm_driver.sv
// HUB75-style panel driver: captures one double-row of multi-bit pixels and
// shows it as COLOUR_DEPTH binary-coded-modulation planes (shift, latch, display).
module led_display_bcm_driver #(
    parameter int NUM_COLS       = 64,
    parameter int NUM_SCAN_ROWS  = 16,
    parameter int COLOUR_DEPTH   = 4,
    parameter int BCLK_DIV       = 4,
    parameter int BASE_OE_CYCLES = 32,
    localparam int ADDR_W        = $clog2(NUM_SCAN_ROWS)
) (
    input  logic                                clk_in,
    input  logic                                n_reset_in,
    input  logic [6*NUM_COLS*COLOUR_DEPTH-1:0]  row_in,
    input  logic                                sof_in,
    input  logic                                row_valid_in,
    output logic                                row_ready_out,
    output logic [2:0]                          rgb_top_out,
    output logic [2:0]                          rgb_bot_out,
    output logic                                bit_clk_out,
    output logic                                latch_out,
    output logic                                oe_n_out,
    output logic [ADDR_W-1:0]                   row_address_out,
    output logic                                frame_done_out
);

    localparam int COL_W   = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int PL_W    = (COLOUR_DEPTH > 1) ? $clog2(COLOUR_DEPTH) : 1;
    localparam int OE_MAX  = BASE_OE_CYCLES << (COLOUR_DEPTH - 1);
    localparam int CNT_MAX = (OE_MAX > BCLK_DIV) ? OE_MAX : BCLK_DIV;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0]  BCLK_LAST = CNT_W'(BCLK_DIV - 1);
    localparam logic [CNT_W-1:0]  BCLK_RISE = CNT_W'(BCLK_DIV / 2 - 1);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(NUM_COLS - 1);
    localparam logic [PL_W-1:0]   PL_LAST   = PL_W'(COLOUR_DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_SCAN_ROWS - 1);

    // Packed so that [col][channel][bit] lands on bit (col*6+ch)*COLOUR_DEPTH+bit.
    typedef logic [NUM_COLS-1:0][5:0][COLOUR_DEPTH-1:0] row_t;
    typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DISPLAY} state_t;

    state_t             state;
    row_t               row_buf;
    logic [PL_W-1:0]    plane;
    logic [COL_W-1:0]   col;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   oe_last;
    logic [ADDR_W-1:0]  next_addr;
    logic [ADDR_W-1:0]  cap_addr;
    logic [5:0]         cap_px;
    logic [5:0]         col_px;
    logic [5:0]         pl_px;

    function automatic logic [5:0] pixel(input row_t r, input logic [COL_W-1:0] c,
                                         input logic [PL_W-1:0] p);
        logic [5:0] px;
        for (int ch = 0; ch < 6; ch++) px[ch] = r[c][ch][p];
        return px;
    endfunction

    always_comb begin
        cap_addr = sof_in ? '0 : next_addr;
        oe_last  = (CNT_W'(BASE_OE_CYCLES) << plane) - CNT_W'(1);
        cap_px   = pixel(row_in, '0, '0);
        col_px   = pixel(row_buf, col + 1'b1, plane);
        pl_px    = pixel(row_buf, '0, plane + 1'b1);
    end

    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            state           <= IDLE;
            row_buf         <= '0;
            plane           <= '0;
            col             <= '0;
            cnt             <= '0;
            next_addr       <= '0;
            row_ready_out   <= 1'b1;
            rgb_top_out     <= '0;
            rgb_bot_out     <= '0;
            bit_clk_out     <= 1'b0;
            latch_out       <= 1'b0;
            oe_n_out        <= 1'b1;
            row_address_out <= '0;
            frame_done_out  <= 1'b0;
        end else begin
            frame_done_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (row_valid_in && row_ready_out) begin
                        row_buf         <= row_in;
                        row_address_out <= cap_addr;
                        next_addr       <= (cap_addr == ADDR_LAST) ? '0 : cap_addr + 1'b1;
                        row_ready_out   <= 1'b0;
                        plane           <= '0;
                        col             <= '0;
                        cnt             <= '0;
                        bit_clk_out     <= 1'b0;
                        rgb_top_out     <= cap_px[2:0];
                        rgb_bot_out     <= cap_px[5:3];
                        state           <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt == BCLK_LAST) begin
                        cnt         <= '0;
                        bit_clk_out <= 1'b0;
                        if (col == COL_LAST) begin
                            latch_out <= 1'b1;
                            state     <= LATCH;
                        end else begin
                            col         <= col + 1'b1;
                            rgb_top_out <= col_px[2:0];
                            rgb_bot_out <= col_px[5:3];
                        end
                    end else begin
                        cnt         <= cnt + 1'b1;
                        bit_clk_out <= (cnt >= BCLK_RISE);
                    end
                end
                LATCH: begin
                    if (cnt == BCLK_LAST) begin
                        cnt       <= '0;
                        latch_out <= 1'b0;
                        oe_n_out  <= 1'b0;
                        state     <= DISPLAY;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DISPLAY: begin
                    if (cnt == oe_last) begin
                        cnt      <= '0;
                        oe_n_out <= 1'b1;
                        if (plane == PL_LAST) begin
                            row_ready_out  <= 1'b1;
                            frame_done_out <= (row_address_out == ADDR_LAST);
                            state          <= IDLE;
                        end else begin
                            plane       <= plane + 1'b1;
                            col         <= '0;
                            rgb_top_out <= pl_px[2:0];
                            rgb_bot_out <= pl_px[5:3];
                            state       <= SHIFT;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
